// File: rtl/sevenseg_if.sv
// Signal bundle between a host, the hex-to-segment decoder and the scan driver.
// The slave side is the scan driver; the master side is everything around it.
interface sevenseg_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        lz_blank;
  logic [3:0]  nib;
  logic [6:0]  ca_in;
  logic [6:0]  ca;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_tick;
  logic        fsm_state;

  // Handshake: load is a single-cycle strobe with no ready; value/dp_en/lz_blank
  // are sampled on every rising edge where load=1, and the last one before a frame
  // boundary wins.
  modport slave (
    input  load, value, dp_en, lz_blank, ca_in,
    output nib, ca, dp, an, digit_idx, frame_tick, fsm_state
  );

  modport master (
    output load, value, dp_en, lz_blank, ca_in,
    input  nib, ca, dp, an, digit_idx, frame_tick, fsm_state
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Four-digit active-low seven-segment scanner with per-slot anode blanking,
// leading-zero suppression and frame-synchronous value updates.
module sevenseg_scan_driver #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input logic       clk,
    input logic       rst_n,
    sevenseg_if.slave bus
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        ftick_q, ftick_d;
    logic [15:0] pend_val_q, pend_val_d, sh_val_q, sh_val_d;
    logic [3:0]  pend_dp_q, pend_dp_d, sh_dp_q, sh_dp_d;
    logic        pend_lz_q, pend_lz_d, sh_lz_q, sh_lz_d;
    logic [6:0]  ca_q, ca_d;
    logic        dp_q, dp_d;
    logic [3:0]  an_q, an_d;

    logic [3:0]  nib;
    logic [3:0]  lz_mask;

    always_comb begin
        nib = sh_val_q[3:0];
        case (idx_q)
            2'd0: nib = sh_val_q[3:0];
            2'd1: nib = sh_val_q[7:4];
            2'd2: nib = sh_val_q[11:8];
            2'd3: nib = sh_val_q[15:12];
            default: nib = sh_val_q[3:0];
        endcase
    end

    // A digit is suppressed when it and every digit to its left are zero.
    always_comb begin
        lz_mask    = 4'b0000;
        lz_mask[3] = sh_lz_q && (sh_val_q[15:12] == 4'h0);
        lz_mask[2] = lz_mask[3] && (sh_val_q[11:8] == 4'h0);
        lz_mask[1] = lz_mask[2] && (sh_val_q[7:4] == 4'h0);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == SLOT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        ftick_d    = 1'b0;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_lz_d  = pend_lz_q;
        sh_val_d   = sh_val_q;
        sh_dp_d    = sh_dp_q;
        sh_lz_d    = sh_lz_q;
        ca_d       = ca_q;
        dp_d       = dp_q;
        an_d       = an_q;

        if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp_en;
            pend_lz_d  = bus.lz_blank;
        end

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    ca_d    = lz_mask[idx_q] ? 7'b1111111 : bus.ca_in;
                    dp_d    = ~sh_dp_q[idx_q];
                    an_d    = ~(4'b0001 << idx_q);
                end
            end
            ST_DRIVE: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d = ST_BLANK;
                    idx_d   = idx_q + 2'd1;
                    ca_d    = 7'b1111111;
                    dp_d    = 1'b1;
                    an_d    = 4'b1111;
                    if (idx_q == 2'd3) begin
                        ftick_d  = 1'b1;
                        // A load coinciding with the boundary goes straight to the shadow.
                        sh_val_d = bus.load ? bus.value    : pend_val_q;
                        sh_dp_d  = bus.load ? bus.dp_en    : pend_dp_q;
                        sh_lz_d  = bus.load ? bus.lz_blank : pend_lz_q;
                    end
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BLANK;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            ftick_q    <= 1'b0;
            pend_val_q <= 16'h0000;
            pend_dp_q  <= 4'h0;
            pend_lz_q  <= 1'b0;
            sh_val_q   <= 16'h0000;
            sh_dp_q    <= 4'h0;
            sh_lz_q    <= 1'b0;
            ca_q       <= 7'b1111111;
            dp_q       <= 1'b1;
            an_q       <= 4'b1111;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            ftick_q    <= ftick_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_lz_q  <= pend_lz_d;
            sh_val_q   <= sh_val_d;
            sh_dp_q    <= sh_dp_d;
            sh_lz_q    <= sh_lz_d;
            ca_q       <= ca_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign bus.nib        = nib;
    assign bus.ca         = ca_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_tick = ftick_q;
    assign bus.fsm_state  = logic'(state_q);

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with 8-cycle slots and 2-cycle blanking.
module tb_sevenseg_scan_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  sevenseg_if sif ();

  sevenseg_scan_driver #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  // stub decoder: pattern never equals all-ones, so blanking is distinguishable
  function automatic logic [6:0] seg(input logic [3:0] n);
    return {n, 3'b010};
  endfunction

  assign sif.ca_in = seg(sif.nib);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // global invariants: at most one anode low, and blank anodes mean blank cathodes
  always @(negedge clk) begin
    check("one_anode", ($countones(~sif.an) <= 1), 1'b1);
    if (sif.an == 4'b1111) begin
      check("blank_ca", sif.ca, 7'b1111111);
      check("blank_dp", sif.dp, 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
    sif.value    = v;
    sif.dp_en    = d;
    sif.lz_blank = lz;
    sif.load     = 1'b1;
    tick();
    sif.load     = 1'b0;
  endtask

  initial begin
    sif.load = 1'b0; sif.value = 16'h0000; sif.dp_en = 4'h0; sif.lz_blank = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", sif.an, 4'b1111);
    check("rst_ca", sif.ca, 7'b1111111);
    check("rst_dp", sif.dp, 1'b1);
    check("rst_idx", sif.digit_idx, 2'd0);
    check("rst_ftick", sif.frame_tick, 1'b0);
    check("rst_state", sif.fsm_state, 1'b0);
    rst_n = 1'b1;
    cyc = 0;

    // blanking then drive of digit 0
    check("blank0_an", sif.an, 4'b1111);
    tick();
    check("blank1_an", sif.an, 4'b1111);
    tick();
    check("drive_an", sif.an, 4'b1110);
    check("drive_ca", sif.ca, seg(4'h0));
    check("drive_state", sif.fsm_state, 1'b1);
    wait_to(7);
    check("drive_end_an", sif.an, 4'b1110);
    wait_to(8);
    check("idx1", sif.digit_idx, 2'd1);
    check("slot1_blank", sif.an, 4'b1111);
    wait_to(10);
    check("slot1_an", sif.an, 4'b1101);
    wait_to(16);
    check("idx2", sif.digit_idx, 2'd2);
    wait_to(24);
    check("idx3", sif.digit_idx, 2'd3);
    wait_to(31);
    check("ftick_pre", sif.frame_tick, 1'b0);
    wait_to(32);
    check("idx_wrap", sif.digit_idx, 2'd0);
    check("ftick", sif.frame_tick, 1'b1);
    tick();
    check("ftick_post", sif.frame_tick, 1'b0);

    // 12AF loaded mid-frame, shown from the next frame (cyc 64)
    do_load(16'h12AF, 4'h0, 1'b0);
    wait_to(63);
    check("old_nib3", sif.nib, 4'h0);
    wait_to(64);
    check("new_nib0_blank", sif.nib, 4'hF);
    check("new_ca_blank", sif.ca, 7'b1111111);
    wait_to(66);
    check("d0_ca", sif.ca, 7'b1111010);
    check("d0_an", sif.an, 4'b1110);
    wait_to(74);
    check("d1_nib", sif.nib, 4'hA);
    check("d1_ca", sif.ca, 7'b1010010);
    check("d1_an", sif.an, 4'b1101);
    wait_to(82);
    check("d2_ca", sif.ca, 7'b0010010);
    check("d2_an", sif.an, 4'b1011);
    wait_to(90);
    check("d3_ca", sif.ca, 7'b0001010);
    check("d3_an", sif.an, 4'b0111);

    // load 1234 while digit 1 is being driven
    wait_to(106);
    do_load(16'h1234, 4'h0, 1'b0);
    wait_to(110);
    check("mid_keep_nib", sif.nib, 4'hA);
    check("mid_keep_ca", sif.ca, 7'b1010010);
    wait_to(130);
    check("mid_new_d0", sif.ca, 7'b0100010);
    wait_to(138);
    check("mid_new_d1", sif.ca, 7'b0011010);

    // load exactly on the boundary edge into cyc 160
    wait_to(159);
    do_load(16'h0050, 4'b0100, 1'b1);
    check("bnd_ftick", sif.frame_tick, 1'b1);
    check("bnd_nib", sif.nib, 4'h0);
    wait_to(162);
    check("lz_d0_ca", sif.ca, 7'b0000010);
    check("lz_d0_dp", sif.dp, 1'b1);
    wait_to(170);
    check("lz_d1_ca", sif.ca, 7'b0101010);
    wait_to(178);
    check("lz_d2_ca", sif.ca, 7'b1111111);
    check("lz_d2_dp", sif.dp, 1'b0);
    check("lz_d2_an", sif.an, 4'b1011);
    wait_to(186);
    check("lz_d3_ca", sif.ca, 7'b1111111);
    check("lz_d3_an", sif.an, 4'b0111);
    check("lz_d3_dp", sif.dp, 1'b1);

    // all-zero value with suppression: only digit 0 lit
    wait_to(193);
    do_load(16'h0000, 4'b0100, 1'b1);
    wait_to(226);
    check("z_d0_ca", sif.ca, 7'b0000010);
    wait_to(234);
    check("z_d1_ca", sif.ca, 7'b1111111);
    check("z_d1_an", sif.an, 4'b1101);
    wait_to(244);
    check("z_d2_an", sif.an, 4'b1011);
    check("z_d2_dp", sif.dp, 1'b0);

    // asynchronous reset during digit 2 drive
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", sif.an, 4'b1111);
    check("arst_ca", sif.ca, 7'b1111111);
    check("arst_dp", sif.dp, 1'b1);
    check("arst_idx", sif.digit_idx, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    check("rr_blank", sif.an, 4'b1111);
    wait_to(2);
    check("rr_an", sif.an, 4'b1110);
    check("rr_ca", sif.ca, 7'b0000010);
    check("rr_dp", sif.dp, 1'b1);
    wait_to(8);
    check("rr_idx1", sif.digit_idx, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
